baseline_est_mc: RTL and testbench

//  Multi-channel ADC baseline estimator. Successor to the single-channel, fixed-length estimator:

---
 rtl/baseline_est_mc.sv | 124 ++++++++++++
 tb/tb_baseline_est_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/baseline_est_mc.sv
// Multi-channel ADC baseline estimator: settle, box-average 2^LOG2N samples, then optional IIR tracking.
// Latency: 1 clk from the final ACCUM sample or a TRACK sample to baseline/bl_valid. No backpressure: in_valid qualifies samples, and there is no ready signal.
module baseline_est_mc #(
  parameter int NCH    = 2,
  parameter int DW     = 14,
  parameter int LOG2N  = 6,
  parameter int SETTLE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dacset,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] indata,
  output logic [NCH*DW-1:0] baseline,
  output logic              bl_valid,
  output logic              busy,
  output logic              done
);

  localparam int AW = DW + LOG2N;
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DONE, S_TRACK} state_t;

  state_t            state;
  logic              sync_meta, sync_q0, sync_q1;
  logic              start;
  logic              mode_q;
  logic [SW-1:0]     settle_cnt;
  logic [LOG2N-1:0]  smp_cnt;
  logic [AW-1:0]     acc     [NCH];
  logic [AW-1:0]     acc_sum [NCH];
  logic [NCH*DW-1:0] acc_res;
  logic signed [DW:0]   diff [NCH];
  logic signed [DW:0]   step [NCH];
  logic signed [DW+1:0] sum  [NCH];
  logic [NCH*DW-1:0] trk_next;
  logic              trk_chg;

  // sync_q0 is the synchronised level; sync_q1 is its delayed copy for edge detection
  assign start = sync_q1 & ~sync_q0;

  always_comb begin
    acc_res  = '0;
    trk_next = '0;
    for (int k = 0; k < NCH; k++) begin
      acc_sum[k] = acc[k] + AW'(indata[k*DW +: DW]);
      acc_res[k*DW +: DW] = acc_sum[k][AW-1:LOG2N];
      diff[k] = $signed({1'b0, indata[k*DW +: DW]}) - $signed({1'b0, baseline[k*DW +: DW]});
      step[k] = diff[k] >>> LOG2N;
      sum[k]  = $signed({2'b00, baseline[k*DW +: DW]}) + $signed({step[k][DW], step[k]});
      // Cannot leave range mathematically; the clamp guards against future edits
      if (sum[k][DW+1])
        trk_next[k*DW +: DW] = '0;
      else if (sum[k][DW])
        trk_next[k*DW +: DW] = '1;
      else
        trk_next[k*DW +: DW] = sum[k][DW-1:0];
    end
    trk_chg = (trk_next != baseline);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta  <= 1'b0;
      sync_q0    <= 1'b0;
      sync_q1    <= 1'b0;
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
      baseline   <= '0;
      bl_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sync_meta <= dacset;
      sync_q0   <= sync_meta;
      sync_q1   <= sync_q0;
      bl_valid  <= 1'b0;
      if (start) begin
        state      <= S_SETTLE;
        mode_q     <= mode;
        settle_cnt <= '0;
        smp_cnt    <= '0;
        for (int k = 0; k < NCH; k++) acc[k] <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SW'(SETTLE - 1))
              state <= S_ACCUM;
            else
              settle_cnt <= settle_cnt + 1'b1;
          end
          S_ACCUM: begin
            if (in_valid) begin
              smp_cnt <= smp_cnt + 1'b1;
              for (int k = 0; k < NCH; k++) acc[k] <= acc_sum[k];
              if (&smp_cnt) begin
                baseline <= acc_res;
                bl_valid <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= mode_q ? S_TRACK : S_DONE;
              end
            end
          end
          S_TRACK: begin
            if (in_valid && trk_chg) begin
              baseline <= trk_next;
              bl_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baseline_est_mc.sv
// Directed bench for baseline_est_mc (NCH=2, DW=14, LOG2N=6, SETTLE=64).
module tb_baseline_est_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dacset;
  logic        mode;
  logic        in_valid;
  logic [27:0] indata;
  logic [27:0] baseline;
  logic        bl_valid;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  bit tog = 0;

  baseline_est_mc #(.NCH(2), .DW(14), .LOG2N(6), .SETTLE(64)) dut (
    .clk(clk), .rst_n(rst_n), .dacset(dacset), .mode(mode), .in_valid(in_valid),
    .indata(indata), .baseline(baseline), .bl_valid(bl_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pack(input int ch1, input int ch0);
    logic [13:0] a, b;
    a = 14'(ch1);
    b = 14'(ch0);
    return {a, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise then drop dacset; busy must appear exactly 3 clk after the fall
  task automatic start_wait(input string tag);
    int n;
    dacset = 1'b1;
    repeat (4) tick();
    dacset = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
  endtask

  task automatic run_busy(input string tag, input int exp_cyc);
    int n, p;
    n = 0;
    p = 0;
    while (busy && n < 1000) begin
      if (tog) begin
        in_valid = n[0];
        indata   = n[0] ? pack(16383, 1000) : pack(16'h3FFF, 16'h3FFF);
      end
      tick();
      n++;
      if (bl_valid) p++;
    end
    chk({tag, "_busy_cyc"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_pulses"}, 64'(p), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int n, p, exp0, x0;
    bit chg;
    rst_n = 1'b0; dacset = 1'b1; mode = 1'b0; in_valid = 1'b0; indata = '0;
    repeat (3) tick();
    chk("rst_baseline", 64'(baseline), 64'd0);
    chk("rst_flags", 64'({bl_valid, busy, done}), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: constant inputs, one-shot
    indata = pack(16383, 1000); in_valid = 1'b1;
    start_wait("s1");
    run_busy("s1", 128);
    chk("s1_baseline", 64'(baseline), 64'(pack(16383, 1000)));
    mode = 1'b1; indata = pack(5, 5);
    repeat (5) tick();
    chk("s1_hold", 64'({baseline, bl_valid, done}), 64'({pack(16383, 1000), 1'b0, 1'b1}));
    mode = 1'b0;

    // 2: ramp, truncating divide
    in_valid = 1'b0;
    start_wait("s2");
    repeat (64) tick();
    chk("s2_old_held", 64'({baseline, busy, done}), 64'({pack(16383, 1000), 1'b1, 1'b0}));
    for (int i = 0; i < 64; i++) begin
      indata = pack(16383 - i, i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("s2_flags", 64'({bl_valid, busy, done}), 64'b101);
    chk("s2_baseline", 64'(baseline), 64'(pack(16351, 31)));

    // 3: in_valid alternating; invalid cycles carry 0x3FFF
    tog = 1;
    start_wait("s3");
    run_busy("s3", 192);
    tog = 0;
    chk("s3_baseline", 64'(baseline), 64'(pack(16383, 1000)));

    // 5: restart at ACCUM sample 30
    indata = pack(200, 500); in_valid = 1'b1;
    start_wait("s5");
    repeat (84) tick();
    dacset = 1'b1;
    repeat (10) tick();
    dacset = 1'b0;
    indata = pack(3000, 2000);
    p = 0;
    for (int i = 1; i <= 131; i++) begin
      tick();
      if (bl_valid) p++;
      if (i == 3)
        chk("s5_restart", 64'({baseline, busy, done}), 64'({pack(16383, 1000), 1'b1, 1'b0}));
    end
    chk("s5_pulses", 64'(p), 64'd1);
    chk("s5_result", 64'({baseline, done}), 64'({pack(3000, 2000), 1'b1}));

    // 4: average then track; mode dropped after start must not matter
    mode = 1'b1; indata = pack(16383, 1000); in_valid = 1'b1;
    start_wait("s4");
    mode = 1'b0;
    run_busy("s4", 128);
    chk("s4_baseline", 64'(baseline), 64'(pack(16383, 1000)));
    tick();
    chk("s4_steady", 64'({baseline, bl_valid}), 64'({pack(16383, 1000), 1'b0}));
    exp0 = 1000;
    indata = pack(16383, 1064);
    tick();
    chk("s4_first_up", 64'({baseline, bl_valid}), 64'({pack(16383, 1001), 1'b1}));
    exp0 = 1001;
    for (int i = 0; i < 1520; i++) begin
      x0 = (i < 20) ? 1064 : 0;
      indata = pack(16383, x0);
      tick();
      chg = ((x0 - exp0) >>> 6) != 0;
      exp0 = exp0 + ((x0 - exp0) >>> 6);
      if (i == 0 || i == 19 || i == 20 || i == 21 || (i % 100) == 50)
        chk("s4_track", 64'({baseline, bl_valid}), 64'({pack(16383, exp0), chg}));
      if (baseline[13:0] > 14'd1064)
        chk("s4_wrap", 64'(baseline[13:0]), 64'(exp0));
    end
    chk("s4_floor", 64'(baseline), 64'(pack(16383, 0)));

    // 6: reset mid-TRACK, then mid-SETTLE
    indata = pack(100, 5000);
    tick();
    rst_n = 1'b0;
    #2;
    chk("s6_trk_rst", 64'({baseline, bl_valid, busy, done}), 64'd0);
    tick();
    rst_n = 1'b1;
    p = 0;
    repeat (20) begin
      tick();
      if (bl_valid) p++;
    end
    chk("s6_trk_idle", 64'({baseline, busy, done, 8'(p)}), 64'd0);
    start_wait("s6");
    repeat (20) tick();
    rst_n = 1'b0;
    #2;
    chk("s6_set_rst", 64'({baseline, bl_valid, busy, done}), 64'd0);
    tick();
    rst_n = 1'b1;
    p = 0;
    n = 0;
    repeat (200) begin
      tick();
      if (bl_valid) p++;
      if (busy || done) n++;
    end
    chk("s6_set_idle", 64'({baseline, 8'(p), 8'(n)}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
